// File: rtl/pp_accum_pkg.sv
// Shared types and helpers for the Booth partial-product accumulator.
package pp_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int num_digits(input int width, input int digit_bits);
      return width / digit_bits;
   endfunction

   function automatic bit digits_ok(input int width, input int digit_bits);
      return (digit_bits > 0) && (width >= digit_bits) && ((width % digit_bits) == 0);
   endfunction

endpackage

// File: rtl/pp_accum_fsm.sv
// Control FSM for the partial-product accumulator: state, digit counter and handshake strobes.
module pp_accum_fsm
   import pp_accum_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int CNT_W      = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic pp_valid,
   input  logic res_ready,
   output logic pp_ready,
   output logic res_valid,
   output logic busy,
   output logic start_acc,
   output logic pp_acc
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_s;

   assign last_s = (cnt_q == CNT_W'(NUM_DIGITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pp_ready  = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      start_acc = 1'b0;
      pp_acc    = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               start_acc = 1'b1;
               cnt_d     = '0;
               state_d   = ACCUM;
            end else begin
               state_d = IDLE;
            end
         end
         ACCUM: begin
            pp_ready = 1'b1;
            if (pp_valid) begin
               pp_acc = 1'b1;
               cnt_d  = cnt_q + CNT_W'(1);
               if (last_s) begin
                  state_d = DONE;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = ACCUM;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            busy    = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/pp_accum_shift_reg.sv
// Sequential radix-2^DIGIT_BITS Booth partial-product accumulator with shift-right product register.
// Optional sticky overflow flag enabled by defining PP_ACCUM_OVF_DETECT_EN.
module pp_accum_shift_reg
   import pp_accum_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DIGIT_BITS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        pp_valid,
   output logic                        pp_ready,
   input  logic [WIDTH+DIGIT_BITS-1:0] pp_data,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [2*WIDTH-1:0]          res_data,
`ifdef PP_ACCUM_OVF_DETECT_EN
   output logic                        ovf,
`endif
   output logic                        busy
);

   localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT_BITS);
   localparam int SUM_W      = WIDTH + DIGIT_BITS;
   localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

   if (!digits_ok(WIDTH, DIGIT_BITS)) begin : g_bad_cfg
      $error("pp_accum_shift_reg: WIDTH must be a non-zero multiple of DIGIT_BITS");
   end

   logic                 start_acc_s;
   logic                 pp_acc_s;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic [SUM_W-1:0]     hi_ext_s;
   logic [SUM_W-1:0]     sum_s;
   logic [2*WIDTH-1:0]   shifted_s;

   pp_accum_fsm #(
      .NUM_DIGITS (NUM_DIGITS),
      .CNT_W      (CNT_W)
   ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pp_valid  (pp_valid),
      .res_ready (res_ready),
      .pp_ready  (pp_ready),
      .res_valid (res_valid),
      .busy      (busy),
      .start_acc (start_acc_s),
      .pp_acc    (pp_acc_s)
   );

   // Upper half is sign-extended so the add wraps modulo 2^SUM_W like a signed adder.
   assign hi_ext_s = {{DIGIT_BITS{p_q[2*WIDTH-1]}}, p_q[2*WIDTH-1:WIDTH]};
   assign sum_s    = hi_ext_s + pp_data;

   if (WIDTH == DIGIT_BITS) begin : g_single_digit
      assign shifted_s = sum_s;
   end else begin : g_multi_digit
      assign shifted_s = {sum_s, p_q[WIDTH-1:DIGIT_BITS]};
   end

   always_comb begin
      p_d = p_q;
      if (start_acc_s) begin
         p_d = '0;
      end else if (pp_acc_s) begin
         p_d = shifted_s;
      end else begin
         p_d = p_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign res_data = p_q;

`ifdef PP_ACCUM_OVF_DETECT_EN
   logic ovf_q, ovf_d;
   logic ovf_beat_s;

   // Signed overflow: operands agree in sign but the wrapped sum does not.
   assign ovf_beat_s = (hi_ext_s[SUM_W-1] == pp_data[SUM_W-1]) &&
                       (sum_s[SUM_W-1] != hi_ext_s[SUM_W-1]);

   always_comb begin
      ovf_d = ovf_q;
      if (start_acc_s) begin
         ovf_d = 1'b0;
      end else if (pp_acc_s && ovf_beat_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
